// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-side responder: word array plus keyboard/display registers,
// fixed-latency access sequencer that raises r for the microsequencer.
module lc3_mem_ctrl #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mio_en,
  input  logic              r_w,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              r,
  input  logic              kb_strobe,
  input  logic [7:0]        kb_char,
  output logic              disp_valid,
  output logic [7:0]        disp_data,
  output logic [1:0]        dbg_state_o
);

  localparam int unsigned DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [15:0] KBSR_A   = 16'hFE00;
  localparam logic [15:0] KBDR_A   = 16'hFE02;
  localparam logic [15:0] DSR_A    = 16'hFE04;
  localparam logic [15:0] DDR_A    = 16'hFE06;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [15:0]         addr_q;
  logic                rw_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                disp_valid_q;
  logic [7:0]          disp_data_q;
  logic                kb_ready_q;
  logic [7:0]          kb_data_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept;
  logic                access;
  logic                in_range;
  logic [DATA_W-1:0]   read_val;

  // Handshake: a request is accepted when mio_en=1 in IDLE; r=1 marks
  // completion and stays up until mio_en falls, then the FSM returns to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mio_en) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (!mio_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'd0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= addr;
        rw_q    <= r_w;
        wdata_q <= wdata;
      end
    end
  end

  assign in_range = (32'(addr_q) < DEPTH);

  always_comb begin
    read_val = '0;
    if (in_range) begin
      read_val = mem_q[addr_q[DEPTH_LOG2-1:0]];
    end else begin
      unique case (addr_q)
        KBSR_A:  read_val = DATA_W'({kb_ready_q, 15'b0});
        KBDR_A:  read_val = DATA_W'({8'b0, kb_data_q});
        DSR_A:   read_val = DATA_W'(16'h8000);
        DDR_A:   read_val = DATA_W'({8'b0, disp_data_q});
        default: read_val = '0;
      endcase
    end
  end

  // Array has no reset; the write is gated by the sequencer, which reset forces to IDLE.
  always_ff @(posedge clk) begin
    if (access && rw_q && in_range) begin
      mem_q[addr_q[DEPTH_LOG2-1:0]] <= wdata_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q      <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= 8'd0;
    end else begin
      disp_valid_q <= 1'b0;
      if (access && !rw_q) rdata_q <= read_val;
      if (access && rw_q && (addr_q == DDR_A)) begin
        disp_valid_q <= 1'b1;
        disp_data_q  <= wdata_q[7:0];
      end
    end
  end

  // A new strobe outranks the clear from a KBDR read on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kb_ready_q <= 1'b0;
      kb_data_q  <= 8'd0;
    end else if (kb_strobe) begin
      kb_ready_q <= 1'b1;
      kb_data_q  <= kb_char;
    end else if (access && !rw_q && (addr_q == KBDR_A)) begin
      kb_ready_q <= 1'b0;
    end
  end

  assign rdata       = rdata_q;
  assign r           = (state_q == DONE);
  assign disp_valid  = disp_valid_q;
  assign disp_data   = disp_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: latency, decode, keyboard/display
// registers, reset abort and mid-access mio_en drop.
module tb_lc3_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mio_en;
  logic        r_w;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        r;
  logic        kb_strobe;
  logic [7:0]  kb_char;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic        dv_at_done;
  logic        dv_after;
  logic [7:0]  dd_at_done;

  lc3_mem_ctrl #(.DATA_W(16), .DEPTH_LOG2(10), .LATENCY(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .mio_en      (mio_en),
    .r_w         (r_w),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .r           (r),
    .kb_strobe   (kb_strobe),
    .kb_char     (kb_char),
    .disp_valid  (disp_valid),
    .disp_data   (disp_data),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full access with operands scrambled during WAIT; checks r holds while
  // mio_en is held and drops one edge after mio_en falls.
  task automatic do_access(input string tag, input logic w, input logic [15:0] a,
                           input logic [15:0] d, output logic [15:0] rd, output int lat);
    @(negedge clk);
    mio_en = 1'b1; r_w = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    r_w = ~w; addr = ~a; wdata = ~d;
    lat = 0;
    while (r !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    rd = rdata;
    dv_at_done = disp_valid;
    dd_at_done = disp_data;
    @(posedge clk); #1;
    dv_after = disp_valid;
    chk({tag, "_r_held"}, 16'(r), 16'h0001);
    @(negedge clk);
    mio_en = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_r_drop"}, 16'(r), 16'h0000);
  endtask

  initial begin
    logic [15:0] rd;
    int          lat;
    int          rises;

    reset = 1'b1; mio_en = 1'b0; r_w = 1'b0; addr = 16'h0; wdata = 16'h0;
    kb_strobe = 1'b0; kb_char = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    // 1: reset state
    chk("rst_r", 16'(r), 16'h0000);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_disp_valid", 16'(disp_valid), 16'h0000);
    chk("rst_disp_data", 16'(disp_data), 16'h0000);
    chk("rst_state", 16'(dbg_state), 16'h0000);
    @(negedge clk); reset = 1'b0;
    do_access("kbsr0", 1'b0, 16'hFE00, 16'h0, rd, lat);
    chk("kbsr0_data", rd, 16'h0000);

    // 2: latency and array write/read
    do_access("wr123", 1'b1, 16'h0123, 16'hABCD, rd, lat);
    chk("wr123_lat", 16'(lat), 16'd4);
    chk("wr123_rdata_held", rd, 16'h0000);
    do_access("rd123", 1'b0, 16'h0123, 16'h0, rd, lat);
    chk("rd123_lat", 16'(lat), 16'd4);
    chk("rd123_data", rd, 16'hABCD);

    // 3: display
    do_access("ddr", 1'b1, 16'hFE06, 16'h1241, rd, lat);
    chk("ddr_dv", 16'(dv_at_done), 16'h0001);
    chk("ddr_dd", 16'(dd_at_done), 16'h0041);
    chk("ddr_dv_pulse", 16'(dv_after), 16'h0000);
    chk("ddr_dd_hold", 16'(disp_data), 16'h0041);
    do_access("dsr", 1'b0, 16'hFE04, 16'h0, rd, lat);
    chk("dsr_data", rd, 16'h8000);
    do_access("ddr_rd", 1'b0, 16'hFE06, 16'h0, rd, lat);
    chk("ddr_rd_data", rd, 16'h0041);

    // 4: keyboard
    @(negedge clk); kb_strobe = 1'b1; kb_char = 8'h61;
    @(negedge clk); kb_strobe = 1'b0; kb_char = 8'h00;
    do_access("kbsr1", 1'b0, 16'hFE00, 16'h0, rd, lat);
    chk("kbsr1_data", rd, 16'h8000);
    do_access("kbdr1", 1'b0, 16'hFE02, 16'h0, rd, lat);
    chk("kbdr1_data", rd, 16'h0061);
    do_access("kbsr2", 1'b0, 16'hFE00, 16'h0, rd, lat);
    chk("kbsr2_data", rd, 16'h0000);
    @(negedge clk); kb_strobe = 1'b1; kb_char = 8'h61;
    @(negedge clk); kb_strobe = 1'b0;
    @(negedge clk);
    mio_en = 1'b1; r_w = 1'b0; addr = 16'hFE02;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    kb_strobe = 1'b1; kb_char = 8'h62;
    @(posedge clk); #1;
    kb_strobe = 1'b0;
    chk("kbdr_coll_r", 16'(r), 16'h0001);
    chk("kbdr_coll_data", rdata, 16'h0061);
    @(negedge clk); mio_en = 1'b0;
    @(posedge clk); #1;
    do_access("kbsr3", 1'b0, 16'hFE00, 16'h0, rd, lat);
    chk("kbsr3_data", rd, 16'h8000);
    do_access("kbdr2", 1'b0, 16'hFE02, 16'h0, rd, lat);
    chk("kbdr2_data", rd, 16'h0062);

    // 5: reset during WAIT aborts a pending write
    do_access("wr10", 1'b1, 16'h0010, 16'h5555, rd, lat);
    @(negedge clk);
    mio_en = 1'b1; r_w = 1'b1; addr = 16'h0010; wdata = 16'h1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_in_wait", 16'(dbg_state), 16'h0001);
    reset = 1'b1;
    #1;
    chk("abort_state", 16'(dbg_state), 16'h0000);
    chk("abort_r", 16'(r), 16'h0000);
    @(negedge clk); reset = 1'b0; mio_en = 1'b0;
    rises = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (r === 1'b1) rises++;
    end
    chk("abort_no_r", 16'(rises), 16'h0000);
    do_access("rd10", 1'b0, 16'h0010, 16'h0, rd, lat);
    chk("rd10_data", rd, 16'h5555);

    // 6: out-of-range drop, no aliasing, unmapped read
    do_access("wr0", 1'b1, 16'h0000, 16'h2222, rd, lat);
    do_access("wr400", 1'b1, 16'h0400, 16'hFFFF, rd, lat);
    do_access("rd400", 1'b0, 16'h0400, 16'h0, rd, lat);
    chk("rd400_data", rd, 16'h0000);
    do_access("rd0", 1'b0, 16'h0000, 16'h0, rd, lat);
    chk("rd0_no_alias", rd, 16'h2222);
    do_access("rdfe08", 1'b0, 16'hFE08, 16'h0, rd, lat);
    chk("rdfe08_data", rd, 16'h0000);

    // mio_en dropped one cycle into WAIT: access still completes, r pulses once
    @(negedge clk);
    mio_en = 1'b1; r_w = 1'b0; addr = 16'h0123;
    @(posedge clk); #1;
    mio_en = 1'b0; addr = 16'h0000;
    lat = 0;
    while (r !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("drop_lat", 16'(lat), 16'd4);
    chk("drop_data", rdata, 16'hABCD);
    @(posedge clk); #1;
    chk("drop_r_pulse", 16'(r), 16'h0000);
    chk("drop_idle", 16'(dbg_state), 16'h0000);
    @(posedge clk); #1;
    chk("drop_stay_idle", 16'(dbg_state), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
